// File: rtl/byte_stream_tx.sv
// byte_stream_tx: accepts one word of up to NBEATS_MAX beats over req/ack and sends it LSB-beat-first with valid/last/ready.
// Ports: clk_i clock; rst_ni async active-low reset; in_req_i/in_ack_o word handshake;
//   in_data_i word (beat k at k*DATA_W); in_len_i beats to send (0 or >NBEATS_MAX means NBEATS_MAX);
//   out_ready_i sink ready; valid_o/last_o/out_o beat stream; busy_o word in flight.
module byte_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int NBEATS_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_req_i,
  output logic                         in_ack_o,
  input  logic [DATA_W*NBEATS_MAX-1:0] in_data_i,
  input  logic [CNT_W-1:0]             in_len_i,
  input  logic                         out_ready_i,
  output logic                         valid_o,
  output logic                         last_o,
  output logic [DATA_W-1:0]            out_o,
  output logic                         busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NBEATS_MAX);
  localparam int WORD_W = DATA_W * NBEATS_MAX;
  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, len_c, cnt_n;
  logic [WORD_W-1:0] word_q, word_d;
  logic              accept, xfer, en;
  assign in_ack_o = state_q == IDLE;
  assign busy_o   = state_q == SEND;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign out_o    = out_q;
  assign accept   = in_req_i && in_ack_o;
  assign xfer     = valid_q && out_ready_i;
  // one enable for the whole datapath so it forms a single gating group
  assign en       = accept || xfer;
  always_comb begin
    len_c   = (in_len_i == '0 || in_len_i > MAX_LEN) ? MAX_LEN : in_len_i;
    cnt_n   = cnt_q + 1'b1;
    word_d  = accept ? in_data_i : word_q;
    len_d   = accept ? len_c : len_q;
    cnt_d   = accept ? '0 : (last_q ? cnt_q : cnt_n);
    // after the final beat out keeps its value; it is don't-care while valid is low
    out_d   = accept ? in_data_i[DATA_W-1:0] : (last_q ? out_q : DATA_W'(word_q >> (cnt_n * DATA_W)));
    last_d  = accept ? (len_c == CNT_W'(1)) : (!last_q && cnt_n == len_q - 1'b1);
    state_d = accept ? SEND : ((xfer && last_q) ? IDLE : state_q);
    valid_d = accept || (valid_q && !(xfer && last_q));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (en) begin
        last_q <= last_d;
        out_q  <= out_d;
        cnt_q  <= cnt_d;
        len_q  <= len_d;
        word_q <= word_d;
      end
    end
  end
endmodule

// File: tb/tb_byte_stream_tx.sv
// tb_byte_stream_tx: directed stimulus with literal expectations plus a queue-based beat model checked every cycle.
module tb_byte_stream_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req;
  logic        in_ack;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        out_ready;
  logic        valid;
  logic        last;
  logic [7:0]  out;
  logic        busy;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t       q[$];
  logic        stalled = 1'b0;
  logic [7:0]  prev_out;
  logic        prev_last;

  byte_stream_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_ack_o(in_ack),
    .in_data_i(in_data), .in_len_i(in_len), .out_ready_i(out_ready),
    .valid_o(valid), .last_o(last), .out_o(out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
      chk("m_rst_valid", valid, 0);
      chk("m_rst_last", last, 0);
      chk("m_rst_out", out, 0);
      chk("m_rst_ack", in_ack, 1);
    end else begin
      chk("m_valid", valid, q.size() != 0);
      chk("m_ack", in_ack, q.size() == 0);
      chk("m_busy", busy, q.size() != 0);
      if (last && !valid) chk("m_last_implies_valid", 0, 1);
      if (stalled) begin
        chk("m_hold_out", out, prev_out);
        chk("m_hold_last", last, prev_last);
      end
      if (valid && q.size() != 0) begin
        chk("m_out", out, q[0].d);
        chk("m_last", last, q[0].l);
      end
      stalled = valid && !out_ready;
      prev_out = out;
      prev_last = last;
      if (valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_req && in_ack) begin
        int n;
        n = (in_len == 0 || in_len > 4) ? 4 : int'(in_len);
        for (int k = 0; k < n; k++) q.push_back('{d: in_data[k*8 +: 8], l: k == n - 1});
      end
    end
  end

  task automatic word(input string tag, input logic [31:0] d, input logic [2:0] len, input int n, input logic [31:0] e);
    @(posedge clk); #1;
    in_data = d; in_len = len; in_req = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk({tag, "_ack"}, in_ack, 1);
    @(posedge clk); #1 in_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, valid, 1);
      chk({tag, "_out"}, out, e[k*8 +: 8]);
      chk({tag, "_last"}, last, k == n - 1);
    end
    @(negedge clk);
    chk({tag, "_end_valid"}, valid, 0);
    chk({tag, "_end_ack"}, in_ack, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_req = 1'b1; out_ready = 1'b1; in_data = 32'h12345678; in_len = 3'd2;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_out", out, 0);
    @(posedge clk); #1 rst_n = 1'b1; in_req = 1'b0;
    @(negedge clk);
    chk("rel_ack", in_ack, 1);
    chk("rel_valid", valid, 0);
    word("w4", 32'hDDCCBBAA, 3'd4, 4, 32'hDDCCBBAA);
    word("w1", 32'h1234565A, 3'd1, 1, 32'h0000005A);
    word("w0", 32'h04030201, 3'd0, 4, 32'h04030201);
    word("w7", 32'h0D0C0B0A, 3'd7, 4, 32'h0D0C0B0A);
    @(posedge clk); #1;
    in_data = 32'h00CCBBAA; in_len = 3'd3; in_req = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_req = 1'b0;
    @(negedge clk); chk("bp_b0", out, 8'hAA);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_out", out, 8'hBB);
      chk("bp_hold_last", last, 0);
      chk("bp_hold_valid", valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("bp_b1", out, 8'hBB);
    @(negedge clk); chk("bp_b2", out, 8'hCC); chk("bp_b2_last", last, 1);
    @(negedge clk); chk("bp_done", valid, 0);
    @(posedge clk); #1;
    in_data = 32'h00002211; in_len = 3'd2; in_req = 1'b1;
    @(posedge clk); #1 in_data = 32'h00004433;
    @(negedge clk); chk("bb_1a", out, 8'h11); chk("bb_1a_ack", in_ack, 0);
    @(negedge clk); chk("bb_1b", out, 8'h22); chk("bb_1b_last", last, 1); chk("bb_1b_ack", in_ack, 0);
    @(negedge clk); chk("bb_idle_valid", valid, 0); chk("bb_idle_ack", in_ack, 1);
    @(posedge clk); #1 in_req = 1'b0;
    @(negedge clk); chk("bb_2a", out, 8'h33); chk("bb_2a_valid", valid, 1);
    @(negedge clk); chk("bb_2b", out, 8'h44); chk("bb_2b_last", last, 1);
    @(negedge clk); chk("bb_done", valid, 0);
    @(posedge clk); #1;
    in_data = 32'h44332211; in_len = 3'd4; in_req = 1'b1;
    @(posedge clk); #1 in_req = 1'b0;
    @(negedge clk); chk("mr_b0", out, 8'h11);
    @(negedge clk); chk("mr_b1", out, 8'h22);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", valid, 0);
    chk("mr_async_last", last, 0);
    chk("mr_async_out", out, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("mr_rel_ack", in_ack, 1); chk("mr_rel_valid", valid, 0);
    word("mr_next", 32'h88776655, 3'd2, 2, 32'h00006655);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
